// File: rtl/cpu_controller.sv
// cpu_controller: instruction fetch, decode and sequencing for the datapath.
// Fetches 16-bit instructions from a synchronous memory into the IR. A Moore
// FSM then drives the datapath controls one step per cycle. The block also
// owns the 9-bit PC, the data-address register and the memory command/address.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   read_data[15:0]       memory read data, valid the cycle after READ is issued
//   datapath_out[15:0]    datapath C register (ALU result / LDR-STR address / STR data)
//   mem_cmd[1:0]          00 NONE, 01 READ, 10 WRITE
//   mem_addr[8:0]         PC for fetch, data_addr for LDR/STR memory states
//   PC[8:0]               program counter
//   write..loads, vsel, readnum, writenum, shift, ALUop   datapath controls
//   sximm8, sximm5        sign-extended IR immediates
//   halt                  high while in HALT
module cpu_controller #(
  parameter logic [8:0] RST_PC = 9'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  input  logic [15:0] datapath_out,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [8:0]  PC,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  vsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        halt
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_MOV_IMM, S_GET_A, S_GET_B,
    S_EXEC, S_WB, S_ADDR, S_LD_DA, S_MEM_RD, S_WB_MEM, S_STR_GETB, S_STR_MOV,
    S_MEM_WR, S_HALT
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_ir;
  logic [8:0]  r_pc;
  logic [8:0]  r_data_addr;

  logic [2:0] w_opcode, w_rn, w_rd, w_rm;
  logic [1:0] w_op, w_sh;
  logic       w_is_cmp, w_is_ldr, w_is_mem;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];
  assign w_is_cmp = ({w_opcode, w_op} == 5'b101_01);
  assign w_is_ldr = (w_opcode == 3'b011);
  // Only LDR/STR with op=00 reach GET_A via the memory path, so opcode alone suffices.
  assign w_is_mem = (w_opcode == 3'b011) || (w_opcode == 3'b100);

  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
  assign PC     = r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RST;
      r_pc        <= RST_PC;
      r_ir        <= 16'd0;
      r_data_addr <= 9'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF2)       r_ir        <= read_data;
      if (r_state == S_UPDATE_PC) r_pc        <= r_pc + 9'd1;
      if (r_state == S_LD_DA)     r_data_addr <= datapath_out[8:0];
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_cmd  = MEM_NONE;
    mem_addr = r_pc;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    vsel     = 2'b00;
    readnum  = 3'd0;
    writenum = 3'd0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    halt     = 1'b0;

    case (r_state)
      S_RST:       w_next = S_IF1;
      S_IF1: begin
        mem_cmd = MEM_READ;
        w_next  = S_IF2;
      end
      S_IF2: begin
        mem_cmd = MEM_READ;
        w_next  = S_UPDATE_PC;
      end
      S_UPDATE_PC: w_next = S_DECODE;
      S_DECODE: begin
        case ({w_opcode, w_op})
          5'b110_10:                     w_next = S_MOV_IMM;
          5'b110_00, 5'b101_11:          w_next = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10,
          5'b011_00, 5'b100_00:          w_next = S_GET_A;
          default:                       w_next = S_HALT;
        endcase
      end
      S_MOV_IMM: begin
        vsel     = 2'b10;
        writenum = w_rn;
        write    = 1'b1;
        w_next   = S_IF1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = w_is_mem ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        shift = w_sh;
        // op field already encodes ADD/CMP/AND/MVN; MOV reg has op=00 (add)
        // and zeroes the A input so the result is just shifted B.
        ALUop = w_op;
        asel  = (w_opcode == 3'b110);
        loads = w_is_cmp;
        loadc = ~w_is_cmp;
        w_next = w_is_cmp ? S_IF1 : S_WB;
      end
      S_WB: begin
        vsel     = 2'b00;
        writenum = w_rd;
        write    = 1'b1;
        w_next   = S_IF1;
      end
      S_ADDR: begin
        bsel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_LD_DA;
      end
      S_LD_DA:     w_next = w_is_ldr ? S_MEM_RD : S_STR_GETB;
      S_MEM_RD: begin
        mem_cmd  = MEM_READ;
        mem_addr = r_data_addr;
        w_next   = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_cmd  = MEM_READ;
        mem_addr = r_data_addr;
        vsel     = 2'b11;
        writenum = w_rd;
        write    = 1'b1;
        w_next   = S_IF1;
      end
      S_STR_GETB: begin
        readnum = w_rd;
        loadb   = 1'b1;
        w_next  = S_STR_MOV;
      end
      S_STR_MOV: begin
        asel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd  = MEM_WRITE;
        mem_addr = r_data_addr;
        w_next   = S_IF1;
      end
      S_HALT:      halt = 1'b1;
      default:     w_next = S_RST;
    endcase

    // Reset aborts any in-flight instruction: nothing may be written this cycle.
    if (reset) begin
      mem_cmd  = MEM_NONE;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      vsel     = 2'b00;
      readnum  = 3'd0;
      writenum = 3'd0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      halt     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: behavioural datapath + synchronous memory around
// the controller; expected register writes, memory writes and per-instruction
// cycle counts are queued per program and popped as the DUT produces them.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] read_data = 16'd0;
  logic [15:0] datapath_out;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr, PC;
  logic        write, loada, loadb, asel, bsel, loadc, loads, halt;
  logic [1:0]  vsel, shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8, sximm5;

  cpu_controller #(.RST_PC(9'd0)) dut (
    .clk(clk), .reset(reset), .read_data(read_data), .datapath_out(datapath_out),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .PC(PC),
    .write(write), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .vsel(vsel), .readnum(readnum),
    .writenum(writenum), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .halt(halt)
  );

  always #5 clk = ~clk;

  // ---------------- datapath + memory model ----------------
  logic [15:0] mem [512];
  logic [15:0] rf  [8];
  logic [15:0] ra, rb, rc;
  logic        rz;
  logic [15:0] wdata, ain, bin, bsh, alu;

  assign datapath_out = rc;

  always_comb begin
    case (vsel)
      2'b11:   wdata = read_data;
      2'b10:   wdata = sximm8;
      2'b01:   wdata = {7'd0, PC};
      default: wdata = rc;
    endcase
    case (shift)
      2'b01:   bsh = {rb[14:0], 1'b0};
      2'b10:   bsh = {1'b0, rb[15:1]};
      2'b11:   bsh = {rb[15], rb[15:1]};
      default: bsh = rb;
    endcase
    ain = asel ? 16'd0 : ra;
    bin = bsel ? sximm5 : bsh;
    case (ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) rf[writenum] <= wdata;
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu;
    if (loads) rz <= (alu == 16'd0);
    if (mem_cmd == 2'b01) read_data <= mem[mem_addr];
    if (mem_cmd == 2'b10) mem[mem_addr] <= rc;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [18:0] q_wr[$];   // {reg, data}
  logic [24:0] q_mw[$];   // {addr, data}
  int          q_cpi[$];

  int          cyc = 0, last_if1 = 0;
  logic        have_if1 = 1'b0, prev_fetch = 1'b0, fetch;
  logic [8:0]  first_if1_addr, last_rd_addr, mov_pc;
  logic [15:0] mov_sx8;
  logic [1:0]  ex_shift, ex_aluop;
  int          n_loads = 0, n_memwr = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      have_if1   = 1'b0;
      prev_fetch = 1'b0;
    end else begin
      fetch = (mem_cmd == 2'b01) && (mem_addr == PC);
      if (fetch && !prev_fetch) begin
        if (!have_if1) first_if1_addr = mem_addr;
        else if (q_cpi.size() == 0) chk("cpi_unexpected", 1, 0);
        else chk("cpi", cyc - last_if1, q_cpi.pop_front());
        have_if1 = 1'b1;
        last_if1 = cyc;
      end
      prev_fetch = fetch;
      if (mem_cmd == 2'b01 && mem_addr != PC) last_rd_addr = mem_addr;
      if (write && vsel == 2'b10) begin mov_sx8 = sximm8; mov_pc = PC; end
      if (loadc && !bsel && !asel) begin ex_shift = shift; ex_aluop = ALUop; end
      if (loads) n_loads++;
    end
    if (write) begin
      if (q_wr.size() == 0) chk("reg_wr_unexpected", {13'd0, writenum, wdata}, 0);
      else chk("reg_wr", {13'd0, writenum, wdata}, {13'd0, q_wr.pop_front()});
    end
    if (mem_cmd == 2'b10) begin
      n_memwr++;
      if (q_mw.size() == 0) chk("mem_wr_unexpected", {7'd0, mem_addr, rc}, 0);
      else chk("mem_wr", {7'd0, mem_addr, rc}, {7'd0, q_mw.pop_front()});
    end
  end

  task automatic begin_phase();
    @(posedge clk); #1 reset = 1'b1;
    q_wr.delete(); q_mw.delete(); q_cpi.delete();
    for (int i = 0; i < 512; i++) mem[i] = 16'hE000;
    for (int i = 0; i < 8; i++) rf[i] = 16'd0;
    n_loads = 0; n_memwr = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while (!(halt && q_wr.size() == 0 && q_mw.size() == 0 && q_cpi.size() == 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    int cnt, n;
    logic [8:0] pc0;
    logic [7:0] b;

    // P1: reset state and MOV R2,#-5
    begin_phase();
    mem[0] = 16'hD2FB;
    q_wr.push_back({3'd2, 16'hFFFB}); q_cpi.push_back(5);
    @(negedge clk);
    chk("rst_mem_cmd", mem_cmd, 0);
    chk("rst_ctrl", {write, loada, loadb, loadc, loads, asel, bsel, halt}, 0);
    chk("rst_pc", PC, 0);
    release_reset();
    run("p1_run", 100);
    chk("p1_if1_addr", first_if1_addr, 0);
    chk("p1_sximm8", mov_sx8, 16'hFFFB);
    chk("p1_pc_at_mov", mov_pc, 1);
    chk("p1_r2", rf[2], 16'hFFFB);

    // P2: ADD R2,R1,R0,LSL#1
    begin_phase();
    rf[0] = 16'd3; rf[1] = 16'd5;
    mem[0] = 16'hA148;
    q_wr.push_back({3'd2, 16'd11}); q_cpi.push_back(8);
    release_reset();
    run("p2_run", 100);
    chk("p2_shift", ex_shift, 2'b01);
    chk("p2_aluop", ex_aluop, 2'b00);

    // P3: CMP R1,R0 with equal operands
    begin_phase();
    rf[0] = 16'd5; rf[1] = 16'd5;
    mem[0] = 16'hA900;
    q_cpi.push_back(7);
    release_reset();
    run("p3_run", 100);
    chk("p3_loads", n_loads, 1);
    chk("p3_z", rz, 1);

    // P4: LDR R3,[R1,#2] then STR R3,[R1,#3]
    begin_phase();
    rf[1] = 16'd4;
    mem[0] = 16'h6162; mem[1] = 16'h8163; mem[6] = 16'h1234;
    q_wr.push_back({3'd3, 16'h1234});
    q_mw.push_back({9'd7, 16'h1234});
    q_cpi.push_back(9); q_cpi.push_back(10);
    release_reset();
    run("p4_run", 100);
    chk("p4_rd_addr", last_rd_addr, 9'd6);
    chk("p4_memwr_cycles", n_memwr, 1);
    chk("p4_mem7", mem[7], 16'h1234);

    // P5: run PC up to 511 with MOVs, HALT at 511 -> PC wraps to 0
    begin_phase();
    for (int i = 0; i < 511; i++) begin
      b = i[7:0];
      mem[i] = {8'hD0, b};
      q_wr.push_back({3'd0, {{8{b[7]}}, b}});
      q_cpi.push_back(5);
    end
    mem[511] = 16'hE000;
    release_reset();
    run("p5_run", 4000);
    pc0 = PC;
    chk("p5_pc_wrap", pc0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halt && PC == pc0 && mem_cmd == 2'b00) cnt++;
    end
    chk("p5_halt_hold", cnt, 20);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("p5_rst_halt", halt, 0);
    chk("p5_rst_pc", PC, 0);

    // P6: reset during WB of an ADD
    begin_phase();
    rf[0] = 16'd3; rf[1] = 16'd5; rf[2] = 16'h7777;
    mem[0] = 16'hA148;
    release_reset();
    n = 0;
    while (!loadc && n < 30) begin @(negedge clk); n++; end
    chk("p6_exec_seen", loadc, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("p6_wb_write", write, 0);
    mem[0] = 16'hE000;
    release_reset();
    run("p6_run", 100);
    chk("p6_r2_kept", rf[2], 16'h7777);
    chk("p6_restart_addr", first_if1_addr, 0);
    chk("p6_pc", PC, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction-fetch, decode and sequencing stage that sits directly upstream of the datapath. It fetches 16-bit instructions from a synchronous memory, holds them in an instruction register (IR), and decodes the register numbers and immediates. A Moore FSM then drives every datapath control input, one step per cycle, until the instruction completes. It also owns the 9-bit PC, the data-address register and the memory command/address interface.

Parameters:
RST_PC, 9'd0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
read_data  in  16  memory read data, valid one cycle after mem_cmd=READ is first presented
datapath_out  in  16  datapath C register (ALU result, LDR/STR address, STR data)
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
mem_addr  out  9  PC during fetch; data_addr during LDR/STR memory states
PC  out  9  program counter, also driven to the datapath PC input
write, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath controls
vsel  out  2  11 mdata, 10 sximm8, 01 PC, 00 datapath_out
readnum, writenum  out  3 each  register select
shift, ALUop  out  2 each  shifter op; ALU op (00 add, 01 sub, 10 and, 11 not B)
sximm8, sximm5  out  16 each  sign-extended IR[7:0] and IR[4:0] (combinational from IR)
halt  out  1  high while in HALT

Behaviour:
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Reset (sync): state<=RST, PC<=RST_PC, IR<=0, data_addr<=0.
- While reset=1, every control output, mem_cmd and halt is forced to 0 combinationally. This also applies mid-instruction: the in-flight instruction is aborted, and no register or memory write occurs in that cycle.
- All outputs are a Moore decode of the registered state, plus IR fields. Any control not listed for a state is 0. readnum and writenum are 0 unless listed.
- RST -> IF1 unconditionally.
- IF1: mem_cmd=READ, mem_addr=PC -> IF2.
- IF2: mem_cmd=READ, mem_addr=PC; IR<=read_data at the clock edge -> UPDATE_PC.
- UPDATE_PC: PC<=PC+1, 9-bit, wraps 511->0 -> DECODE.
- DECODE (no outputs) dispatches on {opcode,op}:
  - 110_10 MOV imm -> MOV_IMM.
  - 110_00 MOV reg, 101_11 MVN -> GET_B.
  - 101_00 ADD, 101_01 CMP, 101_10 AND -> GET_A.
  - 011_00 LDR, 100_00 STR -> GET_A.
  - 111_xx -> HALT.
  - Any other encoding -> HALT.
- MOV_IMM: vsel=10, writenum=Rn, write=1 -> IF1.
- GET_A: readnum=Rn, loada=1. Next state is ADDR for LDR/STR, otherwise GET_B.
- GET_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC: shift=sh, bsel=0.
  - ALUop: ADD 00, CMP 01, AND 10, MVN 11, MOV reg 00 with asel=1. asel=0 for all others.
  - CMP: loads=1, loadc=0 -> IF1.
  - All others: loadc=1 -> WB.
- WB: vsel=00, writenum=Rd, write=1 -> IF1.
- ADDR: asel=0, bsel=1, ALUop=00, loadc=1 -> LD_DA.
- LD_DA: data_addr<=datapath_out[8:0]. Next state is MEM_RD for LDR, STR_GETB for STR.
- MEM_RD: mem_cmd=READ, mem_addr=data_addr -> WB_MEM.
- WB_MEM: mem_cmd=READ, mem_addr=data_addr, vsel=11, writenum=Rd, write=1 -> IF1. mdata is read_data, connected at the top level.
- STR_GETB: readnum=Rd, loadb=1 -> STR_MOV.
- STR_MOV: asel=1, bsel=0, shift=00, ALUop=00, loadc=1 -> MEM_WR.
- MEM_WR: mem_cmd=WRITE, mem_addr=data_addr; write data is datapath_out -> IF1.
- HALT: halt=1, mem_cmd=NONE. Self-loop until reset.
- Cycles per instruction, counted from IF1 to the next IF1: MOV imm 5, CMP 7, MOV reg and MVN 7, ADD and AND 8, LDR 9, STR 10.
- mem_addr defaults to PC in non-memory states.

Test Plan:
- Reset, then memory[0]=16'hD2FB (MOV R2,#-5) -> IF1 has mem_cmd=01, mem_addr=0. Five cycles later R2=16'hFFFB, PC=1, and sximm8=16'hFFFB during MOV_IMM.
- R0=3, R1=5; ADD R2,R1,R0,LSL#1 (16'hA148) -> EXEC has shift=01, ALUop=00. R2=11 at cycle 8; write asserted exactly once.
- R1=5, R0=5; CMP R1,R0 -> loads=1 in EXEC, Z_out=1, no register write, next IF1 at cycle 7.
- R1=4, memory[6]=16'h1234; LDR R3,[R1,#2] (16'h6162) -> mem_addr=6 in MEM_RD; R3=16'h1234. Then STR R3,[R1,#3] writes 16'h1234 to address 7, mem_cmd=10 for one cycle.
- PC=511 fetch -> PC wraps to 0. HALT (16'hE000) -> halt=1 held for 20 cycles, PC frozen; reset -> PC=0, halt=0.
- Reset asserted in the WB cycle of an ADD -> write=0 that cycle, destination register unchanged, restart from RST/IF1 with PC=0.
